// File: rtl/kvs_cmd_arbiter_if.sv
// Requester-side command/response bundle for kvs_cmd_arbiter.
// The master side is the requester pool and the slave side is the arbiter.
interface kvs_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_lock;
    logic [NUM_REQ-1:0]     req_search;
    logic [NUM_REQ-1:0]     req_update;
    logic [NUM_REQ*128-1:0] req_key;
    logic [NUM_REQ*32-1:0]  req_value;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic                   rsp_hit;
    logic [15:0]            rsp_ent_addr;
    logic [31:0]            rsp_value;

    modport master (
        output req_valid, req_lock, req_search, req_update, req_key, req_value,
        input  req_ready, rsp_valid, rsp_hit, rsp_ent_addr, rsp_value
    );

    modport slave (
        input  req_valid, req_lock, req_search, req_update, req_key, req_value,
        output req_ready, rsp_valid, rsp_hit, rsp_ent_addr, rsp_value
    );
endinterface

// File: rtl/kvs_cmd_arbiter.sv
// Round-robin arbiter with burst lock in front of the single Axonerve KVS command port.
// An in-order tag FIFO routes each acknowledge back to the requester that issued the command.
module kvs_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 16
) (
    input  logic                     clk,
    input  logic                     xrst,
    kvs_cmd_arbiter_if.slave         req_if,
    input  logic                     kvs_ready,
    input  logic                     kvs_wait,
    output logic                     kvs_cmd_valid,
    output logic                     kvs_cmd_search,
    output logic                     kvs_cmd_update,
    output logic [127:0]             kvs_key_dat,
    output logic [31:0]              kvs_key_value,
    input  logic                     kvs_ack,
    input  logic                     kvs_hit,
    input  logic [15:0]              kvs_ent_addr,
    input  logic [31:0]              kvs_rsp_value,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(MAX_OUT);
    localparam int CW = AW + 1;

    typedef enum logic {WAIT_RDY = 1'b0, RUN = 1'b1} state_e;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return IW'(sum);
    endfunction

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d, lock_owner_q, lock_owner_d;
    logic                 lock_hold_q, lock_hold_d;
    logic [IW-1:0]        tag_mem_q [MAX_OUT];
    logic [IW-1:0]        tag_mem_d [MAX_OUT];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic                 cmd_valid_q, cmd_valid_d, cmd_search_q, cmd_search_d;
    logic                 cmd_update_q, cmd_update_d;
    logic [127:0]         key_q, key_d;
    logic [31:0]          value_q, value_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_hit_q, rsp_hit_d;
    logic [15:0]          rsp_addr_q, rsp_addr_d;
    logic [31:0]          rsp_value_q, rsp_value_d;
    logic                 err_q, err_d;

    logic                 sel_valid_s, can_issue_s, accept_s, ack_pop_s;
    logic [IW-1:0]        sel_idx_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic [NUM_REQ-1:0]   onehot_one_s;

    assign onehot_one_s = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Grant selection: a held lock pins (or starves) the grant, otherwise round-robin from rr_ptr.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = {IW{1'b0}};
        if (lock_hold_q) begin
            sel_valid_s = req_if.req_valid[lock_owner_q];
            sel_idx_s   = lock_owner_q;
        end else begin
            // Walk downward so the nearest candidate to rr_ptr is written last and wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                sel_idx_s   = req_if.req_valid[wrap_idx(rr_ptr_q, k)] ? wrap_idx(rr_ptr_q, k) : sel_idx_s;
                sel_valid_s = sel_valid_s | req_if.req_valid[wrap_idx(rr_ptr_q, k)];
            end
        end
    end

    // Issue qualification and the combinational ready toward the requesters.
    always_comb begin
        can_issue_s = (state_q == RUN) && !kvs_wait && (outstanding_q < CW'(MAX_OUT));
        accept_s    = can_issue_s && sel_valid_s;
        ack_pop_s   = kvs_ack && (outstanding_q != {CW{1'b0}});
        if (accept_s) begin
            req_ready_s = onehot_one_s << sel_idx_s;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    assign req_if.req_ready = req_ready_s;

    // Next-state computation for the FSM, command register, tag FIFO and response register.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_hold_d   = lock_hold_q;
        lock_owner_d  = lock_owner_q;
        tag_mem_d     = tag_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        cmd_valid_d   = accept_s;
        cmd_search_d  = 1'b0;
        cmd_update_d  = 1'b0;
        key_d         = key_q;
        value_d       = value_q;
        rsp_valid_d   = {NUM_REQ{1'b0}};
        rsp_hit_d     = rsp_hit_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_value_d   = rsp_value_q;
        err_d         = err_q;

        case (state_q)
            WAIT_RDY: state_d = kvs_ready ? RUN : WAIT_RDY;
            RUN:      state_d = kvs_ready ? RUN : WAIT_RDY;
            default:  state_d = WAIT_RDY;
        endcase

        if (accept_s) begin
            cmd_search_d        = req_if.req_search[sel_idx_s];
            cmd_update_d        = req_if.req_update[sel_idx_s];
            key_d               = req_if.req_key[sel_idx_s*128 +: 128];
            value_d             = req_if.req_value[sel_idx_s*32 +: 32];
            tag_mem_d[wr_ptr_q] = sel_idx_s;
            wr_ptr_d            = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            rr_ptr_d            = wrap_idx(sel_idx_s, 1);
            lock_hold_d         = req_if.req_lock[sel_idx_s];
            lock_owner_d        = sel_idx_s;
            err_d = err_d | (req_if.req_search[sel_idx_s] == req_if.req_update[sel_idx_s]);
        end else if (lock_hold_q && !req_if.req_valid[lock_owner_q] && !req_if.req_lock[lock_owner_q]) begin
            lock_hold_d = 1'b0;
        end else begin
            lock_hold_d = lock_hold_q;
        end

        if (ack_pop_s) begin
            rsp_valid_d = onehot_one_s << tag_mem_q[rd_ptr_q];
            rsp_hit_d   = kvs_hit;
            rsp_addr_d  = kvs_ent_addr;
            rsp_value_d = kvs_rsp_value;
            rd_ptr_d    = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            // An acknowledge with nothing in flight has no owner and is dropped.
            err_d = err_d | kvs_ack;
        end

        case ({accept_s, ack_pop_s})
            2'b10:   outstanding_d = outstanding_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   outstanding_d = outstanding_q - {{(CW-1){1'b0}}, 1'b1};
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State register; reset drops everything, including commands still in flight.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q       <= WAIT_RDY;
            rr_ptr_q      <= {IW{1'b0}};
            lock_hold_q   <= 1'b0;
            lock_owner_q  <= {IW{1'b0}};
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_mem_q[i] <= {IW{1'b0}};
            end
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            outstanding_q <= {CW{1'b0}};
            cmd_valid_q   <= 1'b0;
            cmd_search_q  <= 1'b0;
            cmd_update_q  <= 1'b0;
            key_q         <= 128'h0;
            value_q       <= 32'h0;
            rsp_valid_q   <= {NUM_REQ{1'b0}};
            rsp_hit_q     <= 1'b0;
            rsp_addr_q    <= 16'h0;
            rsp_value_q   <= 32'h0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_hold_q   <= lock_hold_d;
            lock_owner_q  <= lock_owner_d;
            tag_mem_q     <= tag_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_search_q  <= cmd_search_d;
            cmd_update_q  <= cmd_update_d;
            key_q         <= key_d;
            value_q       <= value_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_value_q   <= rsp_value_d;
            err_q         <= err_d;
        end
    end

    assign kvs_cmd_valid       = cmd_valid_q;
    assign kvs_cmd_search      = cmd_search_q;
    assign kvs_cmd_update      = cmd_update_q;
    assign kvs_key_dat         = key_q;
    assign kvs_key_value       = value_q;
    assign req_if.rsp_valid    = rsp_valid_q;
    assign req_if.rsp_hit      = rsp_hit_q;
    assign req_if.rsp_ent_addr = rsp_addr_q;
    assign req_if.rsp_value    = rsp_value_q;
    assign outstanding         = outstanding_q;
    assign err                 = err_q;
endmodule

// File: tb/tb_kvs_cmd_arbiter.sv
// Self-checking bench for kvs_cmd_arbiter: a grant table plus hand-written sequences,
// with command and response scoreboards fed from the expected accept order.
module tb_kvs_cmd_arbiter;
    localparam int NR = 4;
    localparam int MO = 16;

    logic        clk = 1'b0;
    logic        xrst;
    logic        kvs_ready, kvs_wait, kvs_ack, kvs_hit;
    logic [15:0] kvs_ent_addr;
    logic [31:0] kvs_rsp_value;
    logic        kvs_cmd_valid, kvs_cmd_search, kvs_cmd_update;
    logic [127:0] kvs_key_dat;
    logic [31:0] kvs_key_value;
    logic [4:0]  outstanding;
    logic        err;

    kvs_cmd_arbiter_if #(.NUM_REQ(NR)) bus ();

    kvs_cmd_arbiter #(.NUM_REQ(NR), .MAX_OUT(MO)) dut (
        .clk(clk), .xrst(xrst), .req_if(bus),
        .kvs_ready(kvs_ready), .kvs_wait(kvs_wait),
        .kvs_cmd_valid(kvs_cmd_valid), .kvs_cmd_search(kvs_cmd_search),
        .kvs_cmd_update(kvs_cmd_update), .kvs_key_dat(kvs_key_dat),
        .kvs_key_value(kvs_key_value), .kvs_ack(kvs_ack), .kvs_hit(kvs_hit),
        .kvs_ent_addr(kvs_ent_addr), .kvs_rsp_value(kvs_rsp_value),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] lock;
        logic          wait_in;
        logic [NR-1:0] ready;
        logic          cmd;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] val;
        logic        hit;
    } ack_t;

    int          checks = 0;
    int          errors = 0;
    int          cmd_q[$];
    logic [3:0]  rsp_q[$];
    ack_t        ack_q[$];
    int          ack_seq = 0;
    int          acc, acc2;
    vec_t        tbl[17];
    int          mon_id;
    logic [3:0]  mon_exp;
    ack_t        mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id);
        cmd_q.push_back(id);
        rsp_q.push_back(4'b0001 << id);
    endtask

    task automatic set_ack(input bit on);
        ack_t a;
        kvs_ack = on;
        if (on) begin
            ack_seq++;
            a.addr = 16'hA000 + 16'(ack_seq);
            a.val  = 32'hBEEF0000 + 32'(ack_seq);
            a.hit  = ack_seq[0];
            kvs_ent_addr  = a.addr;
            kvs_rsp_value = a.val;
            kvs_hit       = a.hit;
            ack_q.push_back(a);
        end
    endtask

    // Output monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (kvs_cmd_valid) begin
            if (cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cmd: got kvs_cmd_valid=1 expected none at %0t", $time);
            end else begin
                mon_id = cmd_q.pop_front();
                chk("cmd_key", kvs_key_dat[127:96], 32'hA5A50000 + 32'(mon_id));
                chk("cmd_value", kvs_key_value, 32'h00001000 + 32'(mon_id));
            end
        end
        if (bus.rsp_valid != 4'b0000) begin
            if (rsp_q.size() == 0 || ack_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%0h expected 0 at %0t", bus.rsp_valid, $time);
            end else begin
                mon_exp = rsp_q.pop_front();
                mon_a   = ack_q.pop_front();
                chk("rsp_route", 32'(bus.rsp_valid), 32'(mon_exp));
                chk("rsp_addr", 32'(bus.rsp_ent_addr), 32'(mon_a.addr));
                chk("rsp_value", bus.rsp_value, mon_a.val);
                chk("rsp_hit", 32'(bus.rsp_hit), 32'(mon_a.hit));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0};
        tbl[1]  = '{4'b0101, 4'b0100, 1'b0, 4'b0100, 1'b1};
        tbl[2]  = '{4'b0101, 4'b0100, 1'b0, 4'b0100, 1'b1};
        tbl[3]  = '{4'b0101, 4'b0100, 1'b0, 4'b0100, 1'b1};
        tbl[4]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1};
        tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1};
        tbl[6]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[7]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0};
        tbl[10] = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[12] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b0};
        tbl[13] = '{4'b0001, 4'b1000, 1'b0, 4'b0000, 1'b1};
        tbl[14] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[15] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};

        xrst = 1'b1; kvs_ready = 1'b0; kvs_wait = 1'b0; kvs_ack = 1'b0;
        kvs_hit = 1'b0; kvs_ent_addr = 16'h0; kvs_rsp_value = 32'h0;
        bus.req_valid = 4'b0000; bus.req_lock = 4'b0000;
        bus.req_search = 4'b1111; bus.req_update = 4'b0000;
        for (int i = 0; i < NR; i++) begin
            bus.req_key[i*128 +: 128] = {4{32'hA5A50000 + 32'(i)}};
            bus.req_value[i*32 +: 32] = 32'h00001000 + 32'(i);
        end
        #2 xrst = 1'b0;
        repeat (2) tick();
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_cmd_valid", 32'(kvs_cmd_valid), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Leave reset with everyone requesting but the KVS not ready.
        xrst = 1'b1; bus.req_valid = 4'b1111;
        tick(); #1;
        chk("ready_in_wait_rdy", 32'(bus.req_ready), 32'd0);
        kvs_ready = 1'b1; #1;
        chk("ready_before_run", 32'(bus.req_ready), 32'd0);

        // Fairness: eight accepts in rotation.
        for (int i = 0; i < 8; i++) push_exp(i % 4);
        tick(); #1;
        chk("run_after_ready", 32'(bus.req_ready), 32'h1);
        acc = 1;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            tick(); #1;
            if ((bus.req_valid & bus.req_ready) != 4'b0000) acc++;
        end
        chk("fair_accepts", 32'(acc), 32'd8);
        tick(); bus.req_valid = 4'b0000; #1;
        chk("fair_outstanding", 32'(outstanding), 32'd8);
        for (int i = 0; i < 8; i++) begin
            set_ack(1'b1);
            tick();
        end
        set_ack(1'b0);
        repeat (2) tick();
        chk("fair_drained", 32'(outstanding), 32'd0);

        // Table: lock burst, kvs_wait stall, round-robin resume, lock starvation.
        for (int r = 0; r < 17; r++) begin
            tick();
            bus.req_valid = tbl[r].valid;
            bus.req_lock  = tbl[r].lock;
            kvs_wait      = tbl[r].wait_in;
            #1;
            chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
            chk($sformatf("tbl%0d_cmd", r), 32'(kvs_cmd_valid), 32'(tbl[r].cmd));
            for (int b = 0; b < NR; b++) begin
                if (tbl[r].ready[b]) push_exp(b);
            end
        end
        tick(); bus.req_valid = 4'b0000; bus.req_lock = 4'b0000; kvs_wait = 1'b0; #1;
        chk("tbl_outstanding", 32'(outstanding), 32'd10);

        // Accept and ack together for ten cycles.
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            push_exp(0);
            set_ack(1'b1);
            tick();
            chk("simul_outstanding", 32'(outstanding), 32'd10);
        end
        bus.req_valid = 4'b0000; set_ack(1'b0);
        for (int i = 0; i < 10; i++) begin
            set_ack(1'b1);
            tick();
        end
        set_ack(1'b0);
        repeat (2) tick();
        chk("simul_drained", 32'(outstanding), 32'd0);

        // Credit limit with acks held off.
        bus.req_valid = 4'b0001; acc = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if ((bus.req_valid & bus.req_ready) != 4'b0000) begin
                acc++; push_exp(0); tick();
            end else begin
                break;
            end
        end
        chk("credit_accepts", 32'(acc), 32'd16);
        chk("credit_outstanding", 32'(outstanding), 32'd16);
        chk("credit_ready", 32'(bus.req_ready), 32'd0);
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
        acc2 = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ((bus.req_valid & bus.req_ready) != 4'b0000) begin
                acc2++; push_exp(0);
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        chk("credit_one_more", 32'(acc2), 32'd1);
        chk("credit_full_again", 32'(outstanding), 32'd16);

        // Asynchronous reset with sixteen commands in flight.
        #3 xrst = 1'b0; #1;
        chk("areset_outstanding", 32'(outstanding), 32'd0);
        chk("areset_err", 32'(err), 32'd0);
        chk("areset_cmd_valid", 32'(kvs_cmd_valid), 32'd0);
        rsp_q.delete(); ack_q.delete();
        tick(); xrst = 1'b1;

        // A late ack for a command lost in reset finds the FIFO empty.
        kvs_ack = 1'b1;
        tick();
        kvs_ack = 1'b0; #1;
        chk("spurious_err", 32'(err), 32'd1);
        chk("spurious_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("spurious_outstanding", 32'(outstanding), 32'd0);

        #1 xrst = 1'b0; #1;
        chk("reset_clears_err", 32'(err), 32'd0);
        tick();

        // Both search and update set: forwarded as-is and flagged.
        xrst = 1'b1; bus.req_update = 4'b1111; bus.req_valid = 4'b0010;
        tick(); #1;
        chk("badtype_ready", 32'(bus.req_ready), 32'h2);
        push_exp(1);
        tick();
        bus.req_valid = 4'b0000; bus.req_update = 4'b0000; #1;
        chk("badtype_search", 32'(kvs_cmd_search), 32'd1);
        chk("badtype_update", 32'(kvs_cmd_update), 32'd1);
        chk("badtype_err", 32'(err), 32'd1);
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
        repeat (2) tick();
        chk("final_outstanding", 32'(outstanding), 32'd0);
        chk("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
